// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants, FSM state type and stream-length helper for the skew feeder.
// Optional macro SKEW_FEEDER_TRANSPOSE_EN is consumed by the top module, not here.
package systolic_pkg;

  localparam int DW = 8;
  localparam logic [DW-1:0] FP_ZERO = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_t;

  // Number of skewed columns needed to push an n x n matrix through n lanes.
  function automatic int stream_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Write port, start/handshake and lane bus of the skew feeder.
// slave is the feeder side, master the side that loads and starts it.
interface systolic_skew_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = $clog2(N)
);

  logic          wr_en;
  logic [AW-1:0] wr_row;
  logic [AW-1:0] wr_col;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic [N*DW-1:0] lane_data;

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, start,
    output busy, done, out_valid, lane_data
  );

  modport master (
    output wr_en, wr_row, wr_col, wr_data, start,
    input  busy, done, out_valid, lane_data
  );

endinterface

// File: rtl/systolic_skew_feeder_skew_lane_sel.sv
// Per-lane element select: lane LANE shows i_vec[t-LANE] while that index is
// inside the vector and the minifloat zero otherwise.
module skew_lane_sel
  import systolic_pkg::*;
#(
  parameter int N    = 4,
  parameter int LANE = 0,
  parameter int TW   = 3
) (
  input  logic [TW-1:0]         i_t,
  input  logic [N-1:0][DW-1:0]  i_vec,
  output logic [DW-1:0]         o_data
);

  always_comb begin
    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    o_data = FP_ZERO;
    for (int j = 0; j < N; j++) begin
      if (i_t == TW'(LANE + j)) o_data = i_vec[j];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Holds an N x N operand matrix and streams it diagonally skewed into the PE array.
// Define SKEW_FEEDER_TRANSPOSE_EN to feed columns (b operand) instead of rows.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave bus
);

  localparam int LEN = stream_len(N);
  localparam int TW  = $clog2(LEN + 1);

  state_t r_state;
  state_t w_next;
  logic [TW-1:0]               r_t;
  logic [N-1:0][N-1:0][DW-1:0] r_mem;
  logic [N-1:0][DW-1:0]        r_lane;
  logic [N-1:0][DW-1:0]        w_lane;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_valid;
  logic                        w_wr_ok;
  logic                        w_start_ok;

  // A start while done is still high is dropped so a restart needs a quiet cycle.
  assign w_start_ok = (r_state == IDLE) && bus.start && !r_done;
  assign w_wr_ok    = (r_state == IDLE) && bus.wr_en &&
                      (int'(bus.wr_row) < N) && (int'(bus.wr_col) < N);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next = STREAM;
      STREAM:  if (r_t == TW'(LEN - 1)) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [N-1:0][DW-1:0] w_vec;
`ifdef SKEW_FEEDER_TRANSPOSE_EN
    for (genvar j = 0; j < N; j++) begin : g_col
      assign w_vec[j] = r_mem[j][i];
    end
`else
    assign w_vec = r_mem[i];
`endif
    skew_lane_sel #(
      .N    (N),
      .LANE (i),
      .TW   (TW)
    ) u_sel (
      .i_t    (r_t),
      .i_vec  (w_vec),
      .o_data (w_lane[i])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the matrix is deliberately reset; an aborted stream must restart from all zeros.
      r_mem   <= '0;
      r_t     <= '0;
      r_lane  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_ok) r_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_t    <= '0;
            r_busy <= 1'b1;
          end
        end
        STREAM: begin
          r_lane  <= w_lane;
          r_valid <= 1'b1;
          r_t     <= r_t + TW'(1);
        end
        FINISH: begin
          r_lane  <= '0;
          r_valid <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out_valid = r_valid;
  assign bus.lane_data = r_lane;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: a reference matrix model fills a
// scoreboard of expected lane columns at each start; columns are popped as they stream.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int N   = 4;
  localparam int LEN = stream_len(N);

  logic clk;
  logic rst;

  systolic_skew_feeder_if #(.N(N), .DW(DW)) bus ();

  systolic_skew_feeder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0]   m [N][N];
  logic [N*DW-1:0] sb_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] exp_col(input int t);
    logic [N*DW-1:0] col;
    col = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = t - i;
      if (j >= 0 && j < N) begin
`ifdef SKEW_FEEDER_TRANSPOSE_EN
        col[i*DW +: DW] = m[j][i];
`else
        col[i*DW +: DW] = m[i][j];
`endif
      end
    end
    return col;
  endfunction

  task automatic write_elem(input int r, input int c, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_row  = r[1:0];
    bus.wr_col  = c[1:0];
    bus.wr_data = d;
    m[r][c]     = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Pulses start, streams one matrix and checks latency, columns and the done pulse.
  task automatic run_stream(input string tag, input bit poke, input bit start_on_done);
    int cnt;
    cnt = 0;
    bus.start = 1'b1;
    for (int t = 0; t < LEN; t++) sb_q.push_back(exp_col(t));
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check({tag, "_busy_rise"}, 64'(bus.busy), 64'(1));
    check({tag, "_valid_latency"}, 64'(bus.out_valid), 64'(0));
    for (int c = 0; c < 4 * N; c++) begin
      if (poke && c == 2) begin
        bus.wr_en   = 1'b1;
        bus.wr_row  = 2'd0;
        bus.wr_col  = 2'd0;
        bus.wr_data = 8'hFF;
        bus.start   = 1'b1;
      end
      tick();
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      if (!bus.out_valid) break;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL %s_extra_col: observed %h expected no column", tag, bus.lane_data);
      end else begin
        check({tag, "_col"}, 64'(bus.lane_data), 64'(sb_q.pop_front()));
      end
      cnt++;
    end
    sb_q.delete();
    check({tag, "_col_count"}, 64'(cnt), 64'(LEN));
    check({tag, "_done_pulse"}, 64'(bus.done), 64'(1));
    check({tag, "_busy_fall"}, 64'(bus.busy), 64'(0));
    check({tag, "_lane_cleared"}, 64'(bus.lane_data), 64'(0));
    if (start_on_done) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_done_fall"}, 64'(bus.done), 64'(0));
    check({tag, "_idle_after"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_row  = '0;
    bus.wr_col  = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = FP_ZERO;

    repeat (2) tick();
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_lane", 64'(bus.lane_data), 64'(0));
    rst = 1'b0;
    tick();

    // Empty matrix, then a start while done is high must be dropped.
    run_stream("zero", 1'b0, 1'b1);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) write_elem(i, j, 8'(8'h10 * i + j));
    run_stream("ramp", 1'b0, 1'b0);

    // Write and start on the same edge: the stream carries the new value.
    bus.wr_en   = 1'b1;
    bus.wr_row  = 2'd2;
    bus.wr_col  = 2'd1;
    bus.wr_data = 8'hAB;
    m[2][1]     = 8'hAB;
    run_stream("wr_start", 1'b0, 1'b0);

    // Writes and starts while busy are ignored, so the replay is unchanged.
    run_stream("poke", 1'b1, 1'b0);
    run_stream("replay", 1'b0, 1'b0);

    // Reset after column t=3 is visible aborts the stream without done.
    bus.start = 1'b1;
    for (int t = 0; t < LEN; t++) sb_q.push_back(exp_col(t));
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_col", 64'(bus.lane_data), 64'(sb_q.pop_front()));
    end
    sb_q.delete();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_valid", 64'(bus.out_valid), 64'(0));
    check("abort_lane", 64'(bus.lane_data), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = FP_ZERO;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2 * N; c++) begin
      tick();
      check("abort_no_done", 64'(bus.done), 64'(0));
    end
    run_stream("post_rst", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
